// File: rtl/ps2_kbcon_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: set-2 prefix and
// drop codes, deframer state encoding, and event/FIFO sizing.
package ps2_kbcon_pkg;

   // Set-2 prefix bytes
   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   // Bytes that never form a key event (errors, BAT result, echo, ack, resend, pause prefix)
   localparam logic [7:0] DROP_ERR0   = 8'h00;
   localparam logic [7:0] DROP_BAT_OK = 8'hAA;
   localparam logic [7:0] DROP_PAUSE  = 8'hE1;
   localparam logic [7:0] DROP_ECHO   = 8'hEE;
   localparam logic [7:0] DROP_ACK    = 8'hFA;
   localparam logic [7:0] DROP_RESEND = 8'hFE;
   localparam logic [7:0] DROP_ERR1   = 8'hFF;

   // Event FIFO sizing
   localparam int EVT_W      = 9;
   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W      = $clog2(FIFO_DEPTH);
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   // Deframer states
   typedef enum logic [1:0] {
      RX_IDLE,
      RX_DATA,
      RX_PAR,
      RX_STOP
   } rx_state_t;

   // One decoded key event: break flag plus (extended) key code
   typedef struct packed {
      logic       brk;
      logic [7:0] code;
   } kb_evt_t;

   function automatic logic is_drop_code(input logic [7:0] b);
      case (b)
         DROP_ERR0, DROP_BAT_OK, DROP_PAUSE, DROP_ECHO,
         DROP_ACK, DROP_RESEND, DROP_ERR1: is_drop_code = 1'b1;
         default:                          is_drop_code = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host deframer: pin synchronizers, KEY_CLK glitch filter,
// 11-bit frame FSM with odd-parity/stop check, and inter-edge timeout.
module ps2_rx
   import ps2_kbcon_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_key_clk,
   input  logic       i_key_in,
   output logic       o_byte_vld,
   output logic [7:0] o_byte
);

   localparam int FCNT_W = $clog2(FILTER_LEN + 1);
   localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);

   logic              r_clk_s1, r_clk_s2;
   logic              r_dat_s1, r_dat_s2;
   logic [FCNT_W-1:0] r_fcnt;
   logic              r_clk_f;
   logic              r_fall;
   rx_state_t         r_state;
   logic [2:0]        r_bitcnt;
   logic [7:0]        r_shift;
   logic              r_par;
   logic [TCNT_W-1:0] r_tcnt;
   logic              r_byte_vld;
   logic [7:0]        r_byte;

   // Two-stage synchronizers for both asynchronous pins (idle level is high)
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
      if (i_rst) begin
         r_clk_s1 <= 1'b1;
         r_clk_s2 <= 1'b1;
         r_dat_s1 <= 1'b1;
         r_dat_s2 <= 1'b1;
      end else begin
         r_clk_s1 <= i_key_clk;
         r_clk_s2 <= r_clk_s1;
         r_dat_s1 <= i_key_in;
         r_dat_s2 <= r_dat_s1;
      end
   end

   // Filtered clock changes only after FILTER_LEN consecutive differing samples
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_fcnt  <= '0;
         r_clk_f <= 1'b1;
         r_fall  <= 1'b0;
      end else begin
         r_fall <= 1'b0;
         if (r_clk_s2 == r_clk_f) begin
            r_fcnt <= '0;
         end else if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
            r_fcnt  <= '0;
            r_clk_f <= r_clk_s2;
            r_fall  <= ~r_clk_s2;
         end else begin
            r_fcnt <= r_fcnt + 1'b1;
         end
      end
   end

   // Frame FSM: start, 8 data bits LSB first, parity, stop; abandons stalled frames
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= RX_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_par      <= 1'b0;
         r_tcnt     <= '0;
         r_byte_vld <= 1'b0;
         r_byte     <= '0;
      end else begin
         r_byte_vld <= 1'b0;

         if (r_fall)
            r_tcnt <= '0;
         else if (r_tcnt != TCNT_W'(TIMEOUT_CYC))
            r_tcnt <= r_tcnt + 1'b1;

         if (r_fall) begin
            case (r_state)
               RX_IDLE: begin
                  if (!r_dat_s2) begin
                     r_state  <= RX_DATA;
                     r_bitcnt <= '0;
                  end
               end
               RX_DATA: begin
                  r_shift  <= {r_dat_s2, r_shift[7:1]};
                  r_bitcnt <= r_bitcnt + 1'b1;
                  if (r_bitcnt == 3'd7)
                     r_state <= RX_PAR;
               end
               RX_PAR: begin
                  r_par   <= r_dat_s2;
                  r_state <= RX_STOP;
               end
               RX_STOP: begin
                  if (r_dat_s2 && (^{r_shift, r_par})) begin
                     r_byte_vld <= 1'b1;
                     r_byte     <= r_shift;
                  end
                  r_state <= RX_IDLE;
               end
               default: r_state <= RX_IDLE;
            endcase
         end else if (r_state != RX_IDLE && r_tcnt >= TCNT_W'(TIMEOUT_CYC - 1)) begin
            r_state <= RX_IDLE;
         end
      end
   end

   assign o_byte_vld = r_byte_vld;
   assign o_byte     = r_byte;

endmodule

// File: rtl/ps2_kbcon.sv
// PS/2 keyboard controller: set-2 make/break/extended decoder feeding a
// 4-entry event FIFO whose head is presented on VK_ON / VK_OFF.
module ps2_kbcon
   import ps2_kbcon_pkg::*;
#(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 20000
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       KEY_CLK,
   input  logic       KEY_IN,
   input  logic       ACK,
   output logic [7:0] VK_ON,
   output logic [7:0] VK_OFF
);

   logic             w_byte_vld;
   logic [7:0]       w_byte;
   logic             w_push;
   kb_evt_t          w_evt;
   logic             w_pop;
   logic             w_full;
   logic             w_wr;
   kb_evt_t          w_head;

   logic             r_brk_pend;
   logic             r_ext_pend;
   logic             r_ack_q;
   kb_evt_t          r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   ps2_rx #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_rx (
      .i_clk      (CLK),
      .i_rst      (RST),
      .i_key_clk  (KEY_CLK),
      .i_key_in   (KEY_IN),
      .o_byte_vld (w_byte_vld),
      .o_byte     (w_byte)
   );

   // Form the event for a non-prefix, non-dropped byte
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_push    = 1'b0;
      w_evt.brk  = r_brk_pend;
      w_evt.code = w_byte | (r_ext_pend ? 8'h80 : 8'h00);
      if (w_byte_vld && w_byte != PFX_BRK && w_byte != PFX_EXT && !is_drop_code(w_byte))
         w_push = 1'b1;
   end

   // Prefix tracking: F0/E0 arm the flags, a real key byte consumes them
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_brk_pend <= 1'b0;
         r_ext_pend <= 1'b0;
      end else if (w_byte_vld) begin
         if (w_byte == PFX_BRK) begin
            r_brk_pend <= 1'b1;
         end else if (w_byte == PFX_EXT) begin
            r_ext_pend <= 1'b1;
         end else if (!is_drop_code(w_byte)) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
         end
      end
   end

   // Pop on ACK rising edge; a push is accepted when not full or when popping
   assign w_pop  = ACK & ~r_ack_q & (r_count != '0);
   assign w_full = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_wr   = w_push & (~w_full | w_pop);
   assign w_head = r_mem[r_rd_ptr];

   // ACK edge detector
   always_ff @(posedge CLK) begin
      if (RST)
         r_ack_q <= 1'b0;
      else
         r_ack_q <= ACK;
   end

   // Event storage
   always_ff @(posedge CLK) begin
      // NOTE: storage is not reset; occupancy is tracked by r_count, so stale entries are never observed.
      if (w_wr)
         r_mem[r_wr_ptr] <= w_evt;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Registered head presentation: make on VK_ON, break on VK_OFF, zero when empty
   always_ff @(posedge CLK) begin
      if (RST || r_count == '0) begin
         VK_ON  <= '0;
         VK_OFF <= '0;
      end else begin
         VK_ON  <= w_head.brk ? 8'h00 : w_head.code;
         VK_OFF <= w_head.brk ? w_head.code : 8'h00;
      end
   end

endmodule

// File: tb/tb_ps2_kbcon.sv
// Self-checking bench for ps2_kbcon: pin-level PS/2 frames in, a prefix-list
// reference model fills an expected-event queue, and a monitor acknowledges
// and compares each event the DUT presents.
module tb_ps2_kbcon;

   localparam int FILTER_LEN  = 8;
   localparam int TIMEOUT_CYC = 20000;
   localparam int HALF        = 20;

   typedef struct {
      bit       brk;
      bit [7:0] code;
   } exp_evt_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       key_clk;
   logic       key_in;
   logic       ack;
   logic [7:0] vk_on;
   logic [7:0] vk_off;

   int         checks   = 0;
   int         failures = 0;
   exp_evt_t   exp_q[$];
   bit [7:0]   pfx_q[$];
   bit         ack_en    = 1'b0;
   bit         force_ack = 1'b0;

   always #5 clk = ~clk;

   ps2_kbcon #(
      .FILTER_LEN  (FILTER_LEN),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .KEY_CLK (key_clk),
      .KEY_IN  (key_in),
      .ACK     (ack),
      .VK_ON   (vk_on),
      .VK_OFF  (vk_off)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // Reference model: a key byte takes its meaning from every prefix seen since the last key
   task automatic model_rx(input bit [7:0] b);
      exp_evt_t e;
      bit       saw_brk;
      bit       saw_ext;
      if (b == 8'hE0 || b == 8'hF0) begin
         pfx_q.push_back(b);
      end else if (!(b inside {8'h00, 8'hAA, 8'hE1, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
         saw_brk = 1'b0;
         saw_ext = 1'b0;
         foreach (pfx_q[i]) begin
            if (pfx_q[i] == 8'hF0) saw_brk = 1'b1;
            else                   saw_ext = 1'b1;
         end
         e.brk  = saw_brk;
         e.code = saw_ext ? (b | 8'h80) : b;
         pfx_q.delete();
         if (exp_q.size() < 4)
            exp_q.push_back(e);
      end
   endtask

   function automatic logic [10:0] mk_frame(input logic [7:0] d, input bit bad_par);
      logic p;
      p = ~(^d);
      if (bad_par) p = ~p;
      return {1'b1, p, d, 1'b0};
   endfunction

   task automatic send_bits(input logic [10:0] frame, input int from, input int upto);
      for (int i = from; i < upto; i++) begin
         key_in = frame[i];
         repeat (5) @(negedge clk);
         key_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         key_clk = 1'b1;
         repeat (HALF - 5) @(negedge clk);
      end
      key_in = 1'b1;
   endtask

   task automatic send_byte(input bit [7:0] b, input bit bad_par);
      if (!bad_par) model_rx(b);
      send_bits(mk_frame(b, bad_par), 0, 11);
      repeat (10) @(negedge clk);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ack) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (8) @(negedge clk);
      check("drain_pending", exp_q.size(), 0);
   endtask

   // Monitor: whenever an event is presented and acking is enabled, compare and consume it
   initial begin
      ack = 1'b0;
      forever begin
         @(negedge clk);
         if (ack_en) begin
            if (vk_on != 8'h00 || vk_off != 8'h00) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_evt", {16'h0, vk_on, vk_off}, 32'h0);
               end else begin
                  exp_evt_t e;
                  e = exp_q.pop_front();
                  check("evt_vk_on",  vk_on,  e.brk ? 8'h00 : e.code);
                  check("evt_vk_off", vk_off, e.brk ? e.code : 8'h00);
               end
               ack = 1'b1;
               repeat (2) @(negedge clk);
               ack = 1'b0;
               repeat (4) @(negedge clk);
            end
         end else begin
            ack = force_ack;
         end
      end
   end

   // Watchdog
   initial begin
      #3_000_000;
      $display("FAIL watchdog: got no completion want completion");
      $fatal(1, "simulation time limit");
   end

   initial begin
      rst     = 1'b1;
      key_clk = 1'b1;
      key_in  = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset_vk_on",  vk_on,  8'h00);
      check("reset_vk_off", vk_off, 8'h00);

      // Make "A" held without ACK
      ack_en = 1'b0;
      send_byte(8'h1C, 1'b0);
      repeat (200) @(negedge clk);
      check("makeA_hold_on",  vk_on,  8'h1C);
      check("makeA_hold_off", vk_off, 8'h00);
      ack_en = 1'b1;
      wait_drain();
      check("makeA_cleared", {vk_on, vk_off}, 16'h0);

      // Extended break (right arrow) then a plain make proves flags cleared
      send_byte(8'hE0, 1'b0);
      send_byte(8'hF0, 1'b0);
      send_byte(8'h74, 1'b0);
      wait_drain();
      send_byte(8'h1C, 1'b0);
      wait_drain();

      // Parity error dropped, next good frame accepted
      send_byte(8'h1C, 1'b1);
      repeat (100) @(negedge clk);
      check("parity_err_none", {vk_on, vk_off}, 16'h0);
      send_byte(8'h1B, 1'b0);
      wait_drain();

      // Timeout after a partial frame
      send_bits(mk_frame(8'h1C, 1'b0), 0, 5);
      repeat (TIMEOUT_CYC + 10) @(negedge clk);
      check("timeout_none", {vk_on, vk_off}, 16'h0);
      send_byte(8'h15, 1'b0);
      wait_drain();

      // FIFO overflow: fifth make is lost
      ack_en = 1'b0;
      send_byte(8'h15, 1'b0);
      send_byte(8'h1D, 1'b0);
      send_byte(8'h24, 1'b0);
      send_byte(8'h2D, 1'b0);
      send_byte(8'h2C, 1'b0);
      repeat (50) @(negedge clk);
      check("ovf_head", vk_on, 8'h15);
      force_ack = 1'b1;
      repeat (20) @(negedge clk);
      force_ack = 1'b0;
      void'(exp_q.pop_front());
      repeat (5) @(negedge clk);
      check("ovf_held_ack_one_pop", vk_on, 8'h1D);
      ack_en = 1'b1;
      wait_drain();
      check("ovf_empty", {vk_on, vk_off}, 16'h0);

      // Reset in the middle of a frame
      send_bits(mk_frame(8'h1C, 1'b0), 0, 5);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pfx_q.delete();
      exp_q.delete();
      send_bits(mk_frame(8'h1C, 1'b0), 5, 11);
      repeat (TIMEOUT_CYC + 10) @(negedge clk);
      check("rst_midframe_none", {vk_on, vk_off}, 16'h0);
      send_byte(8'h1C, 1'b0);
      wait_drain();

      // Randomized prefix/key sequences with occasional corrupted frames
      for (int it = 0; it < 20; it++) begin
         int r;
         r = int'($urandom_range(0, 9));
         if (r < 3)           send_byte(8'hE0, 1'b0);
         if (r >= 2 && r < 6) send_byte(8'hF0, 1'b0);
         send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 7) == 0));
      end
      wait_drain();
      check("final_empty", {vk_on, vk_off}, 16'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
